// File: rtl/mollusc_pkg.sv
// Shared front-end definitions: word size, default encodings and the fetch entry layout.
// Decode imports this package as well.
package mollusc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of fetched {pc, instr} pairs; entry 0 is always the head.
// Flush wins over push and pop.
module fetch_buffer
    import mollusc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic [1:0]   count_q, count_d;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop_i})
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        entry_d[0] = entry_q[1];
                        entry_d[1] = push_data_i;
                    end else begin
                        entry_d[0] = push_data_i;
                    end
                end
                2'b01: begin
                    entry_d[0] = entry_q[1];
                    count_d    = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry_d[0] = push_data_i;
                    end else begin
                        entry_d[1] = push_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '{default: '0};
            count_q <= 2'd0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign head_o  = entry_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: issues sequential word fetches, drops responses made stale by a redirect,
// and feeds decode through a registered pc/instr/valid with a two-entry skid buffer.
module stage_fetch
    import mollusc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            valid
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      discard_q, discard_d;

    logic [XLEN-1:0] target_pc;
    logic            req_fire;
    logic            resp_kept;
    logic            buf_push, buf_pop;
    logic [1:0]      buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    resp_entry;

    assign target_pc = align_word(redirect_pc);

    // Words in flight plus words buffered never exceed the buffer depth, so a stall cannot overflow.
    assign imem_req_valid = !rst && !redirect && (({1'b0, outstanding_q} + {1'b0, buf_count}) < 3'd2);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_kept  = imem_resp_valid && (discard_q == 2'd0);
    assign resp_entry = '{pc: resp_pc_q, instr: imem_resp_data};
    assign buf_pop    = !redirect && !stall && (buf_count != 2'd0);
    assign buf_push   = !redirect && resp_kept && (stall || (buf_count != 2'd0));

    fetch_buffer u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (buf_push),
        .pop_i       (buf_pop),
        .flush_i     (redirect),
        .push_data_i (resp_entry),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, imem_resp_valid};
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = outstanding_q - {1'b0, imem_resp_valid};
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_kept) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else if (imem_resp_valid) begin
                discard_d = discard_q - 2'd1;
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (buf_count != 2'd0) begin
                pc_d    = buf_head.pc;
                instr_d = buf_head.instr;
                valid_d = 1'b1;
            end else if (resp_kept) begin
                pc_d    = resp_pc_q;
                instr_d = imem_resp_data;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            pc_q          <= '0;
            instr_q       <= NOP_INSTR;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
        end
    end

    assign pc    = pc_q;
    assign instr = instr_q;
    assign valid = valid_q;

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Front pipeline stage. Generates sequential instruction addresses, runs an in-order request/response handshake with instruction memory, and buffers returned words. It presents one registered `pc`/`instr` pair per cycle to the decode stage. Jump redirects from later stages flush all in-flight work. Decode back-pressure holds the output register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0000, architectural no-op driven on `instr` whenever `valid` is 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request present.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  response word present. Responses are in order, latency ≥1 cycle, one per cycle max.
- `imem_resp_data`  in  32  instruction word.
- `redirect`  in  1  flush and refetch. Asserted for one cycle by the jump-resolving stage.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `stall`  in  1  decode cannot accept; hold output register.
- `pc`  out  32  address of `instr` (registered).
- `instr`  out  32  instruction to decode (registered).
- `valid`  out  1  `pc`/`instr` hold a real instruction (registered).

## Operation
- **State:**
  - `fetch_pc` (32)
  - `outstanding` (0–2): accepted requests without responses yet, including doomed ones
  - `discard` (0–2): responses still to drop
  - 2-entry buffer with `count` (0–2)
  - output register
- **Issue rule:**
  - `imem_req_valid = !rst && !redirect && (outstanding + count < 2)`.
  - `imem_req_addr = fetch_pc`.
  - On handshake, `fetch_pc += 4` (wraps modulo 2^32) and `outstanding` increments.
  - A pending unaccepted request may be withdrawn by `redirect`. The memory tolerates this.
- **Response:**
  - `imem_resp_valid` decrements `outstanding`.
  - If `discard > 0`, the word is dropped and `discard` decrements.
  - Otherwise the word carries pc = `resp_pc`, an internal counter advanced by 4 per kept response.
- **Output load, when `!stall`:**
  - If buffer non-empty: load head and pop. A same-cycle kept response is pushed.
  - Else if a kept response arrives: bypass it directly into the output register.
  - Else: load `NOP_INSTR`, `valid`=0, `pc` unchanged.
- **Stall:**
  - Output register holds.
  - Kept responses are pushed into the buffer.
  - Overflow cannot occur because of the issue rule.
- **Redirect (highest priority, overrides `stall`):**
  - Next edge: output becomes `NOP_INSTR`/`valid`=0.
  - Buffer cleared.
  - `fetch_pc` and `resp_pc` ← `{redirect_pc[31:2],2'b00}`.
  - `discard` ← `outstanding` − (`imem_resp_valid` ? 1 : 0). The response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
- **Reset:**
  - `pc`=0, `instr`=`NOP_INSTR`, `valid`=0.
  - `fetch_pc`=`resp_pc`=`RESET_PC`; `outstanding`=`discard`=`count`=0.
  - `imem_req_valid`=0 while `rst` is high.
  - Reset mid-transaction abandons in-flight requests. The memory is reset together with this stage.

## Timing
- **First request:** `imem_req_valid` rises in the first cycle after `rst` deasserts.
- **Fetch latency:** a response arriving in cycle t with empty buffer and no stall appears on `pc`/`instr`/`valid` in cycle t+1.
- **Throughput:** with memory latency 1 and `imem_req_ready`=1, one valid instruction per cycle sustained.
- **Redirect penalty:** with latency 1, the first new-path instruction is valid 3 cycles after the redirect cycle. The sequence is:
  - issue at t+1
  - response at t+2
  - output at t+3
- **Stall release:** the buffered head is output on the first edge with `stall`=0. There are no bubbles while the buffer is non-empty.
- **Simultaneous `redirect` and `stall`:** redirect wins.
- **Simultaneous push and pop:** `count` unchanged.

## Structure
- **Shared package `mollusc_pkg`:** `NOP_INSTR` encoding, `RESET_PC` default, `XLEN`=32. The package is shared with decode.
- **Sub-module `fetch_buffer`:**
  - 2-entry FIFO of {pc, instr}.
  - push/pop/flush inputs; head/count outputs.
  - Flush takes priority over push.

## Test plan
- **Reset:** hold `rst` 3 cycles, release.
  - `valid`=0 and `instr`=`NOP_INSTR` during reset.
  - First `imem_req_addr`=`RESET_PC` in the first post-reset cycle.
- **Streaming:** latency-1 memory, `ready`=1, 8 words from 0x100.
  - Outputs 0x100..0x11C on consecutive cycles with `valid`=1.
- **Stall:** assert `stall` 4 cycles mid-stream.
  - Output held.
  - At most 2 requests outstanding plus buffered.
  - After release, the next pcs continue gap-free, no duplicate or lost word.
- **Redirect with 2 outstanding:** latency-3 memory; `redirect` to 0x2000.
  - Both old responses are dropped.
  - The next `valid` output has `pc`=0x2000.
  - A redirect asserted together with `stall` still flushes.
- **Back-pressure from memory:** `ready` toggles randomly.
  - `imem_req_addr` is stable while `valid && !ready`.
  - Output pcs strictly +4 sequential.
- **Wrap:** `redirect_pc`=0xFFFF_FFFC.
  - Outputs 0xFFFF_FFFC then 0x0000_0000.
